// File: rtl/program_counter_sequencer.sv
// Fetch/issue/branch sequencer driving instruction memory and the ALU control path.
// Optional return stack for call/return jumps is enabled by PC_SEQUENCER_RETURN_STACK_EN.
module program_counter_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        zeroflag,
  input  logic        signflag,
  input  logic        overflow,
  input  logic        errorbit,
  output logic        exec_valid,
  output logic [15:0] exec_instruction,
  input  logic        exec_done,
  input  logic        halt_req,
  output logic [15:0] pc,
  output logic        halted
);

  typedef enum logic [2:0] {StIdle, StFetch, StIssue, StBranch, StHalt} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  flags_q, flags_d;  // {errorbit, overflow, signflag, zeroflag}
  logic        br_taken;
  logic        br_call;
  logic        br_ret;
  logic [15:0] br_offset;
  logic [15:0] ret_addr;

`ifdef PC_SEQUENCER_RETURN_STACK_EN
  logic [15:0] stack_q [4];
  logic [1:0]  top_q;
  logic [2:0]  count_q;
  logic        push_en;
  logic        pop_en;

  assign ret_addr = stack_q[top_q];
  assign push_en  = (state_q == StBranch) && br_call;
  assign pop_en   = (state_q == StBranch) && br_ret;

  // Circular buffer: pushing when full overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      top_q   <= 2'd0;
      count_q <= 3'd0;
    end else if (push_en) begin
      top_q                  <= top_q + 2'd1;
      stack_q[top_q + 2'd1]  <= pc_q + 16'd1;
      count_q                <= (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
    end else if (pop_en) begin
      top_q   <= top_q - 2'd1;
      count_q <= count_q - 3'd1;
    end
  end
`else
  assign ret_addr = 16'h0000;
`endif

  assign br_offset = {{8{ir_q[7]}}, ir_q[7:0]};

  always_comb begin
    br_taken = 1'b0;
    br_call  = 1'b0;
    br_ret   = 1'b0;
    unique case (ir_q[11:8])
      4'd0:    br_taken = 1'b1;
      4'd1:    br_taken = flags_q[0];
      4'd2:    br_taken = !flags_q[0];
      4'd3:    br_taken = flags_q[1];
      4'd4:    br_taken = !flags_q[1];
      4'd5:    br_taken = flags_q[2];
      4'd6:    br_taken = flags_q[3];
`ifdef PC_SEQUENCER_RETURN_STACK_EN
      4'd7: begin
        br_taken = 1'b1;
        br_call  = 1'b1;
      end
      4'd8:    br_ret = (count_q != 3'd0);
`endif
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = (imem_data[15:12] == 4'hE) ? StBranch : StIssue;
        end
      end
      StIssue: begin
        if (exec_done) begin
          pc_d    = pc_q + 16'd1;
          flags_d = {errorbit, overflow, signflag, zeroflag};
          state_d = halt_req ? StHalt : StFetch;
        end
      end
      StBranch: begin
        if (br_ret)        pc_d = ret_addr;
        else if (br_taken) pc_d = pc_q + br_offset;
        else               pc_d = pc_q + 16'd1;
        state_d = halt_req ? StHalt : StFetch;
      end
      StHalt: begin
        if (!halt_req) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= 16'h0000;
      ir_q    <= 16'h0000;
      flags_q <= 4'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  assign imem_req         = (state_q == StFetch);
  assign imem_addr        = pc_q;
  assign exec_valid       = (state_q == StIssue);
  assign exec_instruction = ir_q;
  assign pc               = pc_q;
  assign halted           = (state_q == StHalt);

endmodule

// File: doc/program_counter_sequencer.md
PROGRAM_COUNTER_SEQUENCER -- requirements
Module: program_counter_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, synchronous active-low reset).
REQ-002 imem_req  output  1  instruction fetch request.
REQ-003 imem_addr  output  16  fetch address, equal to pc while imem_req=1.
REQ-004 imem_ack  input  1  fetch complete, imem_data valid this cycle.
REQ-005 imem_data  input  16  fetched instruction.
REQ-006 zeroflag, signflag, overflow, errorbit  input  1 each  ALU status of the last executed instruction, valid while exec_done=1.
REQ-007 exec_valid  output  1  instruction offered to the ALU control path.
REQ-008 exec_instruction  output  16  the offered instruction, held stable while exec_valid=1.
REQ-009 exec_done  input  1  ALU control path finished the offered instruction.
REQ-010 halt_req  input  1  stop after the current instruction.
REQ-011 pc  output  16  current program counter.
REQ-012 halted  output  1  sequencer in HALT.

Function
REQ-013 The block SHALL have five states: IDLE, FETCH, ISSUE, BRANCH, HALT.
REQ-014 IDLE SHALL last exactly one cycle after reset and then go to FETCH.
REQ-015 FETCH SHALL hold imem_req=1 and imem_addr=pc until imem_ack=1, then latch imem_data into the instruction register.
REQ-016 A non-jump instruction (imem_data[15:12] != 4'hE) SHALL go to ISSUE.
REQ-017 A jump instruction (imem_data[15:12] == 4'hE) SHALL go to BRANCH and SHALL NOT be issued to the ALU.
REQ-018 ISSUE SHALL hold exec_valid=1 with exec_instruction stable until exec_done=1.
- On exec_done=1: pc <= pc+1, and latch all four flags.
- Next state: FETCH, or HALT if halt_req=1 in that cycle.
REQ-019 BRANCH SHALL take one cycle and evaluate cond=instr[11:8] against the latched flags:
- 0 always
- 1 Z
- 2 !Z
- 3 S
- 4 !S
- 5 V
- 6 E
- 7 call
- 8 return
- 9..15 never
REQ-020 A taken branch SHALL set pc <= pc + sign_extend(instr[7:0]); a not-taken branch SHALL set pc <= pc+1.
- Arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000, and 16'h0000 + (-1) = 16'hFFFF.
REQ-021 After BRANCH the block SHALL go to FETCH, or to HALT if halt_req=1.
REQ-022 Latched flags SHALL reset to 0 and SHALL change only on exec_done=1 in ISSUE.
REQ-023 HALT SHALL set halted=1 and hold pc, and SHALL return to FETCH on the first cycle with halt_req=0.
REQ-024 halt_req asserted during FETCH SHALL NOT abort the fetch; it SHALL take effect at the end of the next ISSUE or BRANCH.
REQ-025 The fetch-to-issue latency SHALL be exactly 1 cycle: exec_valid rises in the cycle after the imem_ack cycle.

Reset
REQ-026 While rst_n=0 at a rising clk edge, the block SHALL set:
- state=IDLE, pc=16'h0000
- imem_req=0, exec_valid=0, halted=0
- instruction register=0, flags=0
REQ-027 Reset SHALL override any in-flight handshake: exec_valid and imem_req drop in the cycle after reset is sampled, with no pc update.

Configuration
REQ-028 With macro PC_SEQUENCER_RETURN_STACK_EN defined, the block SHALL include a 4-entry, 16-bit return stack.
- cond 7 (call) pushes pc+1 and jumps relative.
- cond 8 (return) pops into pc.
- A push when full SHALL overwrite the oldest entry.
- A pop when empty SHALL behave as not-taken (pc+1).
- The stack pointer SHALL reset to empty.
REQ-029 Without PC_SEQUENCER_RETURN_STACK_EN, conds 7 and 8 SHALL be never-taken (pc+1), and no stack storage SHALL exist.

Verification
REQ-030 Reset, then imem_data=16'h1234 acked on the first FETCH -> exec_valid=1 with exec_instruction=16'h1234 on the next cycle; after exec_done, pc=16'h0001.
REQ-031 Jump 16'hE1FC (Z, offset -4) at pc=16'h0010 after an instruction that returned zeroflag=1 -> pc=16'h000C; the same jump with zeroflag=0 -> pc=16'h0011; exec_valid stays 0 during the jump in both cases.
REQ-032 Jump 16'hE001 at pc=16'hFFFF -> pc=16'h0000 (wrap-around).
REQ-033 halt_req=1 during ISSUE with exec_done=1 -> halted=1 on the next cycle with pc=old+1; drop halt_req -> imem_req=1 on the following cycle.
REQ-034 With PC_SEQUENCER_RETURN_STACK_EN: call 16'hE705 at pc=16'h0020 -> pc=16'h0025; a later return 16'hE800 -> pc=16'h0021; five nested calls then five returns -> the fifth return yields pc+1.
REQ-035 rst_n=0 asserted for one cycle while exec_valid=1 and exec_done=0 -> pc=0, exec_valid=0, state IDLE, with no flag update.
